sub_bytes_pipe: RTL and testbench
=================================

Name: sub_bytes_pipe

Overview:
Parametrised, pipelined AES S-box array. Applies SubBytes, or InvSubBytes when the inverse path is compiled in, to NB bytes per beat. Uses the composite-field GF(2^8) inverter (GF_MULINV_8) per byte plus forward/inverse affine logic. Sits between the round-key/ShiftRows datapath and MixColumns. Uses an elastic valid/ready pipeline so the round controller can stall it.

Parameters:
NB, 4, number of byte lanes (1..16); data width is 8*NB.
PIPE, 2, pipeline register stages (1..3); latency in cycles.

Ports:
CLK  input  1  clock, rising edge.
RSTn  input  1  asynchronous active-low reset.
in_valid  input  1  input beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_data  input  8*NB  bytes; lane k = in_data[8k+7:8k].
in_inv  input  1  1 = InvSubBytes for this beat, 0 = SubBytes.
out_valid  output  1  output beat valid.
out_ready  input  1  consumer accepts the output beat.
out_data  output  8*NB  transformed bytes, same lane mapping.
out_inv  output  1  mode bit travelling with the beat.
busy  output  1  any pipeline stage holds a valid beat.

Behaviour:
- Clock and reset: one clock CLK; RSTn asynchronous, active-low. Reset clears all stage valid bits.
- Reset values: out_valid=0, busy=0, in_ready=1, out_inv=0, out_data=0. Data registers also reset to 0.
- Per lane, forward: y = A(GF_inv(x)) ^ 0x63, where A is the standard AES affine matrix. Inverse: y = GF_inv(A^-1(x ^ 0x63)). GF_inv(0x00)=0x00. Lanes are fully independent.
- Datapath segments:
  - S0: pre-affine mux (inverse only).
  - S1: GF inverse.
  - S2: post-affine mux (forward only).
- Register placement by PIPE:
  - PIPE=1: output register only.
  - PIPE=2: after S1, and at output.
  - PIPE=3: after S0, after S1, and at output.
  - Any other PIPE value is an elaboration error.
- Each stage k has a valid bit v[k]. Stage k loads when ready[k] = !v[k] | ready[k+1]; the last stage uses ready = out_ready. in_ready = ready[0], a combinational function of the valid bits and out_ready.
- Handshakes:
  - A beat transfers on in_valid&in_ready and on out_valid&out_ready.
  - Throughput is 1 beat/cycle when out_ready=1.
  - Latency is exactly PIPE cycles from input acceptance to out_valid with an unstalled pipe.
- Stall: out_valid=1 & out_ready=0 holds out_data/out_inv stable. Upstream bubbles collapse: an empty stage still accepts. in_ready drops only when every stage is full.
- Simultaneous accept and emit on a full pipe: both transfer in the same cycle, no bubble.
- in_valid=1 & in_ready=0: input ignored; the producer must hold the beat.
- Mode changes are per beat: in_inv may toggle every beat, and each beat's mode rides with its data.
- busy = OR of all v[k].
- Reset asserted mid-operation: all in-flight beats are dropped immediately (asynchronous). After RSTn rises, outputs are at reset values.

Optional Feature:
SBOX_INV_EN
- Defined: inverse-affine pre-stage and forward/inverse muxes are built; in_inv is honoured.
- Undefined: forward SubBytes only. in_inv is ignored for the datapath but still propagated to out_inv. No inverse-affine logic is synthesised.

Test Plan:
- Forward, NB=4, PIPE=2, out_ready=1: in_data=0x00112233, in_inv=0 -> after 2 cycles out_data=0x638293C3, out_valid=1 for one cycle.
- Inverse (SBOX_INV_EN): in_data=0x63ED7C63, in_inv=1 -> out_data=0x00530100, out_inv=1.
- Back-to-back with mixed modes: 256 consecutive beats cycling lane values 0x00..0xFF, alternating in_inv -> every output matches the golden S-box/InvS-box. in_ready stays 1, no gaps.
- Backpressure, PIPE=3: out_ready=0 for 5 cycles while streaming.
  - in_ready falls after 3 accepted beats.
  - out_data is stable throughout.
  - Raising out_ready drains beats in order, with in_ready=1 the same cycle.
- Reset mid-stream: RSTn low with 2 beats in flight -> out_valid=0, busy=0 with no clock edge. After release, the first new beat 0x00000001 produces 0x6363637C.
- Without SBOX_INV_EN: in_data=0x00000053, in_inv=1 -> out_data=0x636363ED, out_inv=1.

Source files
------------

// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe: NB-lane AES SubBytes; InvSubBytes is built in only when `SBOX_INV_EN is defined.
// Latency: PIPE cycles (1..3) from input acceptance to out_valid; 1 beat/cycle throughput.
// Backpressure: elastic per-stage valid/ready; bubbles collapse, in_ready falls only when all stages are full and out_ready=0.
module sub_bytes_pipe #(
   parameter int NB   = 4,
   parameter int PIPE = 2
) (
   input  logic            CLK,
   input  logic            RSTn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [8*NB-1:0] in_data,
   input  logic            in_inv,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [8*NB-1:0] out_data,
   output logic            out_inv,
   output logic            busy
);
   localparam int DW = 8 * NB;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ ({8{x[7]}} & 8'h1b);
      end
      return p;
   endfunction

   // GF(2^8) inverse through the GF(2^4) subfield: x^17 (the norm) lies in the
   // subfield, where its inverse is N^14; then x^-1 = x^16 * N^14 = x^254.
   // Squarings are linear, so the cost is four general multipliers per lane.
   // Zero maps to zero naturally.
   function automatic logic [7:0] gf_mulinv_8(input logic [7:0] x);
      logic [7:0] x2, x4, x8, x16, n, n2, n4, n8;
      x2  = gf_mul(x, x);
      x4  = gf_mul(x2, x2);
      x8  = gf_mul(x4, x4);
      x16 = gf_mul(x8, x8);
      n   = gf_mul(x16, x);
      n2  = gf_mul(n, n);
      n4  = gf_mul(n2, n2);
      n8  = gf_mul(n4, n4);
      return gf_mul(x16, gf_mul(n2, gf_mul(n4, n8)));
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   // Forward AES affine map including the 0x63 constant.
   function automatic logic [DW-1:0] fwd_bus(input logic [DW-1:0] x);
      logic [DW-1:0] y;
      logic [7:0]    b;
      for (int k = 0; k < NB; k++) begin
         b = x[8*k +: 8];
         y[8*k +: 8] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      end
      return y;
   endfunction

   function automatic logic [DW-1:0] inv_bus(input logic [DW-1:0] x);
      logic [DW-1:0] y;
      for (int k = 0; k < NB; k++) y[8*k +: 8] = gf_mulinv_8(x[8*k +: 8]);
      return y;
   endfunction

`ifdef SBOX_INV_EN
   // Inverse affine A^-1(x ^ 0x63); the constant folds to 0x05 after the rotations.
   function automatic logic [DW-1:0] pre_inv_bus(input logic [DW-1:0] x);
      logic [DW-1:0] y;
      logic [7:0]    b;
      for (int k = 0; k < NB; k++) begin
         b = x[8*k +: 8];
         y[8*k +: 8] = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
      end
      return y;
   endfunction
`endif

   logic [PIPE-1:0]         v;
   logic [PIPE-1:0]         m;
   logic [PIPE-1:0][DW-1:0] d;
   logic [PIPE:0]           rdy;
   logic [PIPE-1:0]         up_v;
   logic [PIPE-1:0]         up_m;
   logic [PIPE-1:0][DW-1:0] st_in;
   logic [DW-1:0]           s0_out;
   logic [DW-1:0]           s1_in;
   logic [DW-1:0]           s1_out;
   logic [DW-1:0]           s2_in;
   logic [DW-1:0]           s2_out;
`ifdef SBOX_INV_EN
   logic                    s2_inv;
`endif

   // S0: inverse beats pass through the inverse affine map before inversion.
   always_comb begin
`ifdef SBOX_INV_EN
      s0_out = in_inv ? pre_inv_bus(in_data) : in_data;
`else
      s0_out = in_data;
`endif
   end

   assign s1_out = inv_bus(s1_in);

   // S2: forward beats get the forward affine map after inversion.
   always_comb begin
`ifdef SBOX_INV_EN
      s2_out = s2_inv ? s2_in : fwd_bus(s2_in);
`else
      s2_out = fwd_bus(s2_in);
`endif
   end

   // Register placement: segments collapse into fewer stages as PIPE shrinks.
   generate
      if (NB < 1 || NB > 16) begin : g_bad_nb
         $error("sub_bytes_pipe: NB must be in 1..16");
      end
      if (PIPE == 1) begin : g_p1
         assign s1_in    = s0_out;
         assign s2_in    = s1_out;
         assign st_in[0] = s2_out;
`ifdef SBOX_INV_EN
         assign s2_inv   = in_inv;
`endif
      end else if (PIPE == 2) begin : g_p2
         assign s1_in    = s0_out;
         assign s2_in    = d[0];
         assign st_in[0] = s1_out;
         assign st_in[1] = s2_out;
`ifdef SBOX_INV_EN
         assign s2_inv   = m[0];
`endif
      end else if (PIPE == 3) begin : g_p3
         assign s1_in    = d[0];
         assign s2_in    = d[1];
         assign st_in[0] = s0_out;
         assign st_in[1] = s1_out;
         assign st_in[2] = s2_out;
`ifdef SBOX_INV_EN
         assign s2_inv   = m[1];
`endif
      end else begin : g_bad_pipe
         $error("sub_bytes_pipe: PIPE must be in 1..3");
      end
   endgenerate

   // Ready ripples back from the consumer: a stage accepts if empty or draining.
   always_comb begin
      rdy[PIPE] = out_ready;
      for (int k = PIPE - 1; k >= 0; k--) rdy[k] = !v[k] | rdy[k+1];
   end

   // Upstream valid/mode feeding each stage.
   always_comb begin
      up_v[0] = in_valid;
      up_m[0] = in_inv;
      for (int k = 1; k < PIPE; k++) begin
         up_v[k] = v[k-1];
         up_m[k] = m[k-1];
      end
   end

   // Stage registers: reload whenever the stage can accept; data only moves with a valid beat.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         v <= '0;
         m <= '0;
         d <= '0;
      end else begin
         for (int k = 0; k < PIPE; k++) begin
            if (rdy[k]) begin
               v[k] <= up_v[k];
               if (up_v[k]) begin
                  d[k] <= st_in[k];
                  m[k] <= up_m[k];
               end
            end
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = v[PIPE-1];
   assign out_data  = d[PIPE-1];
   assign out_inv   = m[PIPE-1];
   assign busy      = |v;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
`timescale 1ns/1ps
module tb_sub_bytes_pipe;
`ifdef SBOX_INV_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        in_valid, in_inv, out_ready, sel;
   logic [31:0] in_data;
   logic        rdy2, ov2, oi2, busy2;
   logic        rdy3, ov3, oi3, busy3;
   logic [31:0] od2, od3;
   logic        in_ready_m, out_valid_m, out_inv_m, busy_m;
   logic [31:0] out_data_m;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  sbox  [256];
   logic [7:0]  isbox [256];
   logic [32:0] sb [$];
   logic        last_acc, stall_prev, stall_inv;
   logic [31:0] stall_dat;
   int          cur_pipe;
   int          nacc;
   int          lim;

   always #5 CLK = ~CLK;

   sub_bytes_pipe #(.NB(4), .PIPE(2)) u2 (
      .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid & ~sel), .in_ready(rdy2),
      .in_data(in_data), .in_inv(in_inv), .out_valid(ov2), .out_ready(out_ready),
      .out_data(od2), .out_inv(oi2), .busy(busy2));

   sub_bytes_pipe #(.NB(4), .PIPE(3)) u3 (
      .CLK(CLK), .RSTn(RSTn), .in_valid(in_valid & sel), .in_ready(rdy3),
      .in_data(in_data), .in_inv(in_inv), .out_valid(ov3), .out_ready(out_ready),
      .out_data(od3), .out_inv(oi3), .busy(busy3));

   assign in_ready_m  = sel ? rdy3  : rdy2;
   assign out_valid_m = sel ? ov3   : ov2;
   assign out_data_m  = sel ? od3   : od2;
   assign out_inv_m   = sel ? oi3   : oi2;
   assign busy_m      = sel ? busy3 : busy2;
   assign cur_pipe    = sel ? 3 : 2;

   // Carry-less product followed by reduction by 0x11B.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] aff(input logic [7:0] b);
      logic [7:0] s;
      logic [7:0] c;
      c = 8'h63;
      for (int i = 0; i < 8; i++)
         s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      return s;
   endfunction

   function automatic logic [31:0] exp_beat(input logic [31:0] dat, input logic inv);
      logic [31:0] r;
      for (int k = 0; k < 4; k++)
         r[8*k +: 8] = (inv && INV_EN) ? isbox[dat[8*k +: 8]] : sbox[dat[8*k +: 8]];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock: observe handshakes at the falling edge, update the scoreboard, return 1ns after the rising edge.
   task automatic cycle();
      logic [32:0] e;
      @(negedge CLK);
      check("in_ready_model", in_ready_m, (sb.size() < cur_pipe) || out_ready);
      check("busy_model", busy_m, sb.size() != 0);
      if (stall_prev) begin
         check("stall_hold_valid", out_valid_m, 1);
         check("stall_hold_data", out_data_m, stall_dat);
         check("stall_hold_inv", out_inv_m, stall_inv);
      end
      if (sb.size() == 0) begin
         check("out_valid_without_beat", out_valid_m, 0);
      end else if (out_valid_m && out_ready) begin
         e = sb.pop_front();
         check("out_data_sb", out_data_m, e[31:0]);
         check("out_inv_sb", out_inv_m, e[32]);
      end
      last_acc = in_valid && in_ready_m;
      if (last_acc) sb.push_back({in_inv, exp_beat(in_data, in_inv)});
      stall_prev = out_valid_m && !out_ready;
      stall_dat  = out_data_m;
      stall_inv  = out_inv_m;
      @(posedge CLK);
      #1;
   endtask

   // Single beat into an idle pipe: checks latency, value, mode and one-cycle out_valid.
   task automatic directed(input string tag, input logic [31:0] dat, input logic inv,
                           input logic [31:0] exp_d);
      int lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = dat;
      in_inv    = inv;
      cycle();
      check({tag, "_accept"}, last_acc, 1);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid_m && lat < 10) begin
         cycle();
         lat++;
      end
      check({tag, "_latency"}, lat, cur_pipe);
      check({tag, "_data"}, out_data_m, exp_d);
      check({tag, "_inv"}, out_inv_m, inv);
      cycle();
      check({tag, "_valid_one_cycle"}, out_valid_m, 0);
   endtask

   initial begin
      for (int x = 0; x < 256; x++) begin
         logic [7:0] xi;
         xi = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
         sbox[x] = aff(xi);
      end
      for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);

      sel = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
      last_acc = 1'b0; stall_prev = 1'b0; stall_inv = 1'b0; stall_dat = '0;
      RSTn = 1'b0;
      #23;
      check("rst_p2_out_valid", ov2, 0);
      check("rst_p2_busy", busy2, 0);
      check("rst_p2_in_ready", rdy2, 1);
      check("rst_p2_out_inv", oi2, 0);
      check("rst_p2_out_data", od2, 32'h0);
      check("rst_p3_out_valid", ov3, 0);
      check("rst_p3_busy", busy3, 0);
      check("rst_p3_in_ready", rdy3, 1);
      check("rst_p3_out_data", od3, 32'h0);
      @(negedge CLK);
      RSTn = 1'b1;
      @(posedge CLK);
      #1;

      directed("fwd", 32'h00112233, 1'b0, 32'h638293C3);
`ifdef SBOX_INV_EN
      directed("inv", 32'h63ED7C63, 1'b1, 32'h00530100);
`else
      directed("noinv", 32'h00000053, 1'b1, 32'h636363ED);
`endif

      // 256 back-to-back beats, every lane value, alternating modes.
      out_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         in_valid = 1'b1;
         in_inv   = i[0];
         for (int k = 0; k < 4; k++) in_data[8*k +: 8] = 8'(i + 64*k);
         cycle();
         check("b2b_accept", last_acc, 1);
         if (i >= 1) check("b2b_out_valid", out_valid_m, 1);
      end
      in_valid = 1'b0;
      repeat (2) cycle();
      check("b2b_no_gap_drain", sb.size(), 0);

      // Random traffic with random backpressure; producer holds a refused beat.
      for (int c = 0; c < 400; c++) begin
         if (!in_valid || last_acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = $urandom;
            in_inv   = 1'($urandom_range(0, 1));
         end
         out_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      lim = 0;
      while (sb.size() != 0 && lim < 10) begin
         cycle();
         lim++;
      end
      check("rand_drain", sb.size(), 0);

      // PIPE=3 backpressure: five cycles of out_ready=0 while streaming.
      sel = 1'b1;
      out_ready = 1'b0;
      nacc = 0;
      in_valid = 1'b1;
      in_data  = $urandom;
      in_inv   = 1'($urandom_range(0, 1));
      for (int c = 0; c < 5; c++) begin
         check("bp_in_ready", in_ready_m, nacc < 3);
         cycle();
         if (last_acc) begin
            nacc++;
            in_data = $urandom;
            in_inv  = 1'($urandom_range(0, 1));
         end
      end
      check("bp_accepted", nacc, 3);
      check("bp_in_ready_low", in_ready_m, 0);
      check("bp_out_valid", out_valid_m, 1);
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_same_cycle", in_ready_m, 1);
      for (int c = 0; c < 3; c++) begin
         cycle();
         if (last_acc) begin
            in_data = $urandom;
            in_inv  = 1'($urandom_range(0, 1));
         end
      end
      in_valid = 1'b0;
      lim = 0;
      while (sb.size() != 0 && lim < 10) begin
         cycle();
         lim++;
      end
      check("bp_drain", sb.size(), 0);

      // Asynchronous reset with two beats in flight.
      sel = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_inv   = 1'b1;
      in_data  = $urandom;
      cycle();
      in_data  = $urandom;
      cycle();
      in_valid = 1'b0;
      check("rst_pre_busy", busy_m, 1);
      #1;
      RSTn = 1'b0;
      #1;
      check("rst_async_out_valid", out_valid_m, 0);
      check("rst_async_busy", busy_m, 0);
      check("rst_async_in_ready", in_ready_m, 1);
      check("rst_async_out_data", out_data_m, 32'h0);
      check("rst_async_out_inv", out_inv_m, 0);
      sb.delete();
      stall_prev = 1'b0;
      @(negedge CLK);
      RSTn = 1'b1;
      @(posedge CLK);
      #1;
      check("rst_after_out_valid", out_valid_m, 0);
      directed("post_rst", 32'h00000001, 1'b0, 32'h6363637C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
